// File: rtl/parity_check_stage.sv
// rtl/parity_check_stage.sv - parity check, strip and 2-entry skid buffer for parity FIFO pop side
// Optional macro PARITY_CHECK_DROP_EN: drop words failing parity instead of forwarding them flagged.
module parity_check_stage #(
    parameter int DATA_WIDTH        = 8,
    parameter bit PARITY_MODE       = 1'b0,  // 0: EVEN, 1: ODD
    parameter bit PARITY_BIT_CHOICE = 1'b0,  // 0: MSB,  1: LSB
    parameter int CNT_WIDTH         = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  grant_o,
    output logic                  valid_o,
    output logic [DATA_WIDTH-2:0] data_o,
    output logic                  parity_err_o,
    input  logic                  grant_i,
    input  logic                  err_clear_i,
    output logic [CNT_WIDTH-1:0]  err_count_o
);

    localparam int PW = DATA_WIDTH - 1;

    logic [1:0]           r_count;
    logic [PW-1:0]        r_data0;
    logic [PW-1:0]        r_data1;
    logic                 r_err0;
    logic                 r_err1;
    logic [CNT_WIDTH-1:0] r_err_cnt;

    logic          w_parity;
    logic          w_bad;
    logic [PW-1:0] w_payload;
    logic          w_push;
    logic          w_pop;
    logic          w_wr;
    logic          w_wr_err;

    assign w_parity  = ^data_i;
    assign w_bad     = PARITY_MODE ? ~w_parity : w_parity;
    assign w_payload = PARITY_BIT_CHOICE ? data_i[DATA_WIDTH-1:1] : data_i[DATA_WIDTH-2:0];

    // grant depends only on the occupancy register, so upstream sees no path from grant_i/valid_i
    assign grant_o = (r_count != 2'd2) && !reset;
    assign valid_o = (r_count != 2'd0) && !reset;

    assign w_push = valid_i && grant_o;
    assign w_pop  = valid_o && grant_i;

`ifdef PARITY_CHECK_DROP_EN
    assign w_wr     = w_push && !w_bad;
    assign w_wr_err = 1'b0;
`else
    assign w_wr     = w_push;
    assign w_wr_err = w_bad;
`endif

    assign data_o       = r_data0;
    assign parity_err_o = r_err0;
    assign err_count_o  = r_err_cnt;

    // Entry 0 is always the head; entry 1 only holds a word while count==2.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= 2'd0;
            r_data0 <= '0;
            r_data1 <= '0;
            r_err0  <= 1'b0;
            r_err1  <= 1'b0;
        end else begin
            case ({w_wr, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_data0 <= w_payload;
                        r_err0  <= w_wr_err;
                    end else begin
                        r_data1 <= w_payload;
                        r_err1  <= w_wr_err;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    // head keeps its value after the last pop so data_o holds while idle
                    if (r_count == 2'd2) begin
                        r_data0 <= r_data1;
                        r_err0  <= r_err1;
                    end
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd2) begin
                        r_data0 <= r_data1;
                        r_err0  <= r_err1;
                        r_data1 <= w_payload;
                        r_err1  <= w_wr_err;
                    end else begin
                        r_data0 <= w_payload;
                        r_err0  <= w_wr_err;
                    end
                end
                default: ;
            endcase
        end
    end

    // Clear wins over the old value but still counts an erroneous word arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_cnt <= '0;
        end else if (err_clear_i) begin
            r_err_cnt <= (w_push && w_bad) ? CNT_WIDTH'(1) : '0;
        end else if (w_push && w_bad && (r_err_cnt != {CNT_WIDTH{1'b1}})) begin
            r_err_cnt <= r_err_cnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_parity_check_stage.sv
// tb/tb_parity_check_stage.sv - scoreboard bench for parity_check_stage (EVEN/MSB and ODD/LSB instances)
module tb_parity_check_stage;

`ifdef PARITY_CHECK_DROP_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       a_valid_i, a_grant_o, a_valid_o, a_perr, a_grant_i, a_clr;
    logic [7:0] a_data_i, a_cnt;
    logic [6:0] a_data_o;

    logic       b_valid_i, b_grant_o, b_valid_o, b_perr, b_grant_i, b_clr;
    logic [7:0] b_data_i;
    logic [1:0] b_cnt;
    logic [6:0] b_data_o;

    parity_check_stage #(.DATA_WIDTH(8), .PARITY_MODE(1'b0), .PARITY_BIT_CHOICE(1'b0), .CNT_WIDTH(8)) dut_a (
        .clk(clk), .reset(reset), .valid_i(a_valid_i), .data_i(a_data_i), .grant_o(a_grant_o),
        .valid_o(a_valid_o), .data_o(a_data_o), .parity_err_o(a_perr), .grant_i(a_grant_i),
        .err_clear_i(a_clr), .err_count_o(a_cnt)
    );

    parity_check_stage #(.DATA_WIDTH(8), .PARITY_MODE(1'b1), .PARITY_BIT_CHOICE(1'b1), .CNT_WIDTH(2)) dut_b (
        .clk(clk), .reset(reset), .valid_i(b_valid_i), .data_i(b_data_i), .grant_o(b_grant_o),
        .valid_o(b_valid_o), .data_o(b_data_o), .parity_err_o(b_perr), .grant_i(b_grant_i),
        .err_clear_i(b_clr), .err_count_o(b_cnt)
    );

    int n_chk = 0;
    int n_err = 0;
    int a_pops = 0;
    logic [7:0] qa[$];
    logic [7:0] qb[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // returns {err, payload}
    function automatic logic [7:0] model(input logic [7:0] d, input bit odd, input bit lsb);
        logic e;
        e = odd ? ~(^d) : (^d);
        return {e, (lsb ? d[7:1] : d[6:0])};
    endfunction

    always @(negedge clk) begin
        logic [7:0] e;
        if (reset) begin
            qa.delete();
            qb.delete();
        end else begin
            if (a_valid_o && a_grant_i) begin
                a_pops++;
                if (qa.size() == 0) chk("a_unexpected_out", 1, 0);
                else begin
                    e = qa.pop_front();
                    chk("a_data", a_data_o, e[6:0]);
                    chk("a_perr", a_perr, e[7]);
                end
            end
            if (a_valid_i && a_grant_o) begin
                e = model(a_data_i, 1'b0, 1'b0);
                if (!(DROP && e[7])) qa.push_back(e);
            end
            if (b_valid_o && b_grant_i) begin
                if (qb.size() == 0) chk("b_unexpected_out", 1, 0);
                else begin
                    e = qb.pop_front();
                    chk("b_data", b_data_o, e[6:0]);
                    chk("b_perr", b_perr, e[7]);
                end
            end
            if (b_valid_i && b_grant_o) begin
                e = model(b_data_i, 1'b1, 1'b1);
                if (!(DROP && e[7])) qb.push_back(e);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        logic [7:0] w3[3];
        logic [6:0] p;
        int pops0;
        reset = 1'b1;
        {a_valid_i, a_grant_i, a_clr, b_valid_i, b_grant_i, b_clr} = '0;
        a_data_i = '0;
        b_data_i = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", a_valid_o, 0);
        chk("rst_data", a_data_o, 0);
        chk("rst_perr", a_perr, 0);
        chk("rst_cnt", a_cnt, 0);
        chk("rst_grant", a_grant_o, 0);
        reset = 1'b0;
        #1;
        chk("grant_after_rst", a_grant_o, 1);

        // single good word, then single bad word
        a_grant_i = 1'b1;
        a_valid_i = 1'b1; a_data_i = 8'b1000_0001;
        @(posedge clk); #1;
        a_valid_i = 1'b0;
        chk("good_valid", a_valid_o, 1);
        chk("good_data", a_data_o, 7'h01);
        chk("good_perr", a_perr, 0);
        chk("good_cnt", a_cnt, 0);
        @(posedge clk); #1;
        a_valid_i = 1'b1; a_data_i = 8'b0000_0001;
        @(posedge clk); #1;
        a_valid_i = 1'b0;
        chk("bad_valid", a_valid_o, !DROP);
        if (!DROP) begin
            chk("bad_data", a_data_o, 7'h01);
            chk("bad_perr", a_perr, 1);
        end
        chk("bad_cnt", a_cnt, 1);
        @(posedge clk); #1;

        // fill with downstream stalled, third word held upstream
        a_grant_i = 1'b0;
        w3[0] = 8'h81; w3[1] = 8'h03; w3[2] = 8'h05;
        for (int i = 0; i < 2; i++) begin
            a_valid_i = 1'b1; a_data_i = w3[i];
            chk("fill_grant", a_grant_o, 1);
            @(posedge clk); #1;
        end
        a_data_i = w3[2];
        chk("full_grant", a_grant_o, 0);
        @(posedge clk); #1;
        chk("full_grant_hold", a_grant_o, 0);
        chk("full_head", a_data_o, 7'h01);
        a_grant_i = 1'b1;
        #1;
        chk("drain0_valid", a_valid_o, 1);
        @(posedge clk); #1;
        chk("drain1_data", a_data_o, 7'h03);
        chk("drain1_grant", a_grant_o, 1);
        @(posedge clk); #1;
        a_valid_i = 1'b0;
        chk("drain2_data", a_data_o, 7'h05);
        @(posedge clk); #1;
        chk("drained_valid", a_valid_o, 0);
        chk("drained_hold", a_data_o, 7'h05);

        // 16-word stream, no bubbles
        pops0 = a_pops;
        for (int i = 0; i < 16; i++) begin
            p = 7'($urandom_range(0, 127));
            a_valid_i = 1'b1; a_data_i = {^p, p};
            if (i > 0) chk("stream_valid", a_valid_o, 1);
            chk("stream_grant", a_grant_o, 1);
            @(posedge clk); #1;
        end
        a_valid_i = 1'b0;
        chk("stream_last_valid", a_valid_o, 1);
        @(posedge clk); #1;
        chk("stream_end_valid", a_valid_o, 0);
        chk("stream_pops", a_pops - pops0, 16);
        chk("stream_cnt", a_cnt, 1);

        // ODD/LSB, 2-bit saturating counter
        b_grant_i = 1'b1;
        w3[0] = 8'h03;
        b_valid_i = 1'b1; b_data_i = 8'b0000_0011;
        @(posedge clk); #1;
        if (!DROP) begin
            chk("odd_perr", b_perr, 1);
            chk("odd_data", b_data_o, 7'h01);
        end
        chk("sat_cnt0", b_cnt, 1);
        for (int i = 1; i < 5; i++) begin
            b_data_i = 8'h05 + 8'(i);
            if (^b_data_i) b_data_i = b_data_i ^ 8'h80;
            @(posedge clk); #1;
            chk("sat_cnt", b_cnt, (i + 1 > 3) ? 3 : i + 1);
        end
        b_clr = 1'b1; b_data_i = 8'h0C;
        @(posedge clk); #1;
        chk("clr_with_err", b_cnt, 1);
        b_valid_i = 1'b0;
        @(posedge clk); #1;
        b_clr = 1'b0;
        chk("clr_only", b_cnt, 0);

        // fill to two entries then reset
        b_grant_i = 1'b0;
        w3[0] = 8'h03; w3[1] = 8'h01; w3[2] = 8'h07;
        for (int k = 0; k < 3; k++) begin
            b_valid_i = 1'b1; b_data_i = w3[k];
            @(posedge clk); #1;
        end
        b_valid_i = 1'b0;
        chk("b_full_grant", b_grant_o, 0);
        chk("b_full_valid", b_valid_o, 1);
        chk("b_full_cnt", b_cnt, 1);
        reset = 1'b1;
        #1;
        chk("midrst_grant", b_grant_o, 0);
        chk("midrst_valid", b_valid_o, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("post_rst_valid", b_valid_o, 0);
        chk("post_rst_cnt", b_cnt, 0);
        chk("post_rst_data", b_data_o, 0);
        chk("post_rst_grant", b_grant_o, 1);
        @(posedge clk); #1;
        chk("a_queue_empty", qa.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/parity_check_stage.md
Name: parity_check_stage

Overview:
- Downstream consumer of the parity FIFO `top`.
- Accepts parity-protected words from the FIFO pop interface (valid/data/grant), checks parity, strips the parity bit and forwards the payload with an error flag.
- Contains a 2-entry buffer so upstream grant is register-derived and throughput is one word per cycle.
- Keeps a saturating parity-error counter for status.

Parameters:
- DATA_WIDTH, 8, width of the incoming word including the parity bit.
- PARITY_MODE, EVEN, types_pkg parity mode (EVEN/ODD) used by the upstream FIFO.
- PARITY_BIT_CHOICE, MSB, types_pkg position of the parity bit in the word (MSB/LSB).
- CNT_WIDTH, 8, width of the error counter.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- valid_i  in  1  upstream word valid (from FIFO valid_o).
- data_i  in  DATA_WIDTH  upstream word incl. parity bit (from FIFO data_o).
- grant_o  out  1  this block accepts; drives FIFO grant_i.
- valid_o  out  1  payload valid to downstream.
- data_o  out  DATA_WIDTH-1  payload with parity bit removed.
- parity_err_o  out  1  parity error on the word currently presented on data_o.
- grant_i  in  1  downstream accepts.
- err_clear_i  in  1  synchronous clear of the error counter.
- err_count_o  out  CNT_WIDTH  saturating count of accepted erroneous words.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Transfers: an input transfer occurs on a rising edge with valid_i && grant_o. An output transfer occurs with valid_o && grant_i.
- Parity check:
  - p = XOR of all DATA_WIDTH bits.
  - EVEN: error iff p==1. ODD: error iff p==0.
- Payload extraction:
  - MSB: data_i[DATA_WIDTH-2:0].
  - LSB: data_i[DATA_WIDTH-1:1].
- Buffer: 2 entries, FIFO order. Each entry holds {payload, err}. Occupancy register count in {0,1,2}.
- grant_o:
  - grant_o = (count != 2) && !reset.
  - No combinational path from grant_i or valid_i to grant_o.
- Latency:
  - A word accepted at edge N is presented on valid_o/data_o in the cycle after edge N (1 cycle).
  - Back-to-back words with grant_i held high give one word per cycle.
- Output outputs:
  - valid_o = (count != 0). data_o and parity_err_o come from the head entry.
  - Head is stable while valid_o && !grant_i.
  - When valid_o=0, data_o and parity_err_o hold their last value; they are 0 after reset.
- Occupancy updates on each edge:
  - Push only: count+1.
  - Pop only: count-1.
  - Push and pop together: count unchanged, order preserved.
  - count==2: grant_o=0, so no push; a pop in that cycle re-enables grant_o the next cycle.
  - count==0: no pop possible.
- Error counter:
  - Increments on each input transfer whose parity fails.
  - Saturates at 2^CNT_WIDTH-1 and holds.
  - err_clear_i sets it to 0. If err_clear_i and an error transfer happen in the same cycle, the result is 1.
- Reset values: valid_o=0, data_o=0, parity_err_o=0, err_count_o=0, count=0, grant_o=0 while reset is high.
- Reset mid-operation: buffered words are discarded, with no output transfer in the reset cycle. grant_o=1 in the first cycle after reset deasserts.

Optional Feature:
- Macro: PARITY_CHECK_DROP_EN.
- Defined:
  - Words failing parity are accepted (handshake completes) but not written to the buffer.
  - err_count_o still increments.
  - parity_err_o is tied to 0.
  - Good words keep 1-cycle latency and their order.
- Undefined: every accepted word is forwarded, with parity_err_o flagging bad words.

Test Plan (DATA_WIDTH=8, EVEN, MSB unless stated):
- Reset, then valid_i=1, data_i=8'b1000_0001 at cycle 1, grant_i=1 -> cycle 2: valid_o=1, data_o=7'b000_0001, parity_err_o=0, err_count_o=0.
- data_i=8'b0000_0001 accepted -> next cycle: parity_err_o=1, data_o=7'b000_0001, err_count_o=1. With PARITY_CHECK_DROP_EN: valid_o=0, err_count_o=1.
- grant_i=0, push 3 good words 0x81, 0x03, 0x05 on consecutive cycles -> grant_o drops to 0 after 2 accepts and the third is held upstream. Raising grant_i drains 7'h01, 7'h03, 7'h05 in order, one per cycle.
- Continuous valid_i and grant_i for 16 words -> 16 output transfers in 16 consecutive cycles, no bubble, grant_o constantly 1.
- CNT_WIDTH=2, push 5 bad words -> err_count_o = 1,2,3,3,3. Then err_clear_i together with a bad word -> err_count_o=1.
- PARITY_MODE=ODD, PARITY_BIT_CHOICE=LSB, data_i=8'b0000_0011 -> parity_err_o=1, data_o=7'b000_0001. Then reset asserted while count=2 -> next cycle valid_o=0, err_count_o=0.
